// File: rtl/regfile_dump_uart_tx_if.sv
// Bundle between the register-file dump reader and its surroundings:
// start request, one combinational read port and the UART status/line.
`timescale 1ns/1ps
interface regfile_dump_uart_tx_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     dump_req;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     tx;
  logic                     busy;
  logic                     done;

  modport master (
    input  dump_req, rd_data,
    output rd_addr, tx, busy, done
  );

  modport slave (
    output dump_req, rd_data,
    input  rd_addr, tx, busy, done
  );
endinterface

// File: rtl/regfile_dump_uart_tx.sv
// Walks every register through one read port and streams them as an 8N1 UART
// frame: 0xA5 header, register bytes (reg 0 first, MSB byte first), XOR checksum.
`timescale 1ns/1ps
module regfile_dump_uart_tx #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int CLKS_PER_BIT  = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_dump_uart_tx_if.master bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_REGS - 1);
  localparam logic [BC_W-1:0]          LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [7:0]               HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, DATA, CSUM, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         clk_cnt;
  logic [3:0]               bit_idx;   // 0 = start, 1..8 = data bits, 9 = stop
  logic [BC_W-1:0]          byte_cnt;
  logic [ADDRESS_WIDTH-1:0] rd_addr_r;
  logic                     tx_r;
  logic                     busy_r;
  logic                     done_r;

  logic [7:0]               tx_byte;
  logic [DATA_WIDTH-1:0]    shreg;
  logic [7:0]               csum;

  logic bit_end;
  logic byte_end;

  assign bit_end     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_end    = bit_end && (bit_idx == 4'd9);
  assign bus.rd_addr = rd_addr_r;
  assign bus.tx      = tx_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // Line level for a given bit slot of the 8N1 character.
  function automatic logic bit_level(input logic [7:0] b, input logic [3:0] idx);
    logic [2:0] k;
    k = 3'(idx - 4'd1);
    if (idx == 4'd0)      bit_level = 1'b0;
    else if (idx >= 4'd9) bit_level = 1'b1;
    else                  bit_level = b[k];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      rd_addr_r <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            state     <= HDR;
            busy_r    <= 1'b1;
            tx_r      <= 1'b0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            rd_addr_r <= '0;
          end
        end
        HDR, DATA, CSUM: begin
          if (!bit_end) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else if (bit_idx != 4'd9) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            tx_r    <= bit_level(tx_byte, bit_idx + 4'd1);
          end else begin
            // Stop bit complete: either chain the next byte or change phase.
            clk_cnt <= '0;
            bit_idx <= '0;
            case (state)
              HDR: begin
                state     <= LOAD;
                tx_r      <= 1'b1;
                rd_addr_r <= '0;
              end
              DATA: begin
                if (byte_cnt == LAST_BYTE) begin
                  byte_cnt <= '0;
                  if (rd_addr_r == LAST_ADDR) begin
                    state <= CSUM;
                    tx_r  <= 1'b0;
                  end else begin
                    rd_addr_r <= rd_addr_r + 1'b1;
                    state     <= LOAD;
                    tx_r      <= 1'b1;
                  end
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                  tx_r     <= 1'b0;
                end
              end
              default: begin
                state     <= DONE;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                tx_r      <= 1'b1;
                rd_addr_r <= '0;
              end
            endcase
          end
        end
        LOAD: begin
          state    <= DATA;
          tx_r     <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          byte_cnt <= '0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte/shift/checksum datapath; follows the control decisions above.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.dump_req) begin
      tx_byte <= HDR_BYTE;
      csum    <= 8'h00;
    end else if (state == LOAD) begin
      tx_byte <= bus.rd_data[DATA_WIDTH-1 -: 8];
      shreg   <= bus.rd_data << 8;
      csum    <= csum ^ bus.rd_data[DATA_WIDTH-1 -: 8];
    end else if (state == DATA && byte_end) begin
      if (byte_cnt != LAST_BYTE) begin
        tx_byte <= shreg[DATA_WIDTH-1 -: 8];
        shreg   <= shreg << 8;
        csum    <= csum ^ shreg[DATA_WIDTH-1 -: 8];
      end else if (rd_addr_r == LAST_ADDR) begin
        tx_byte <= csum;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_uart_tx.sv
// Directed bench for the register-file UART dumper: a byte scoreboard fed by a
// reference frame builder, compared against bytes decoded from the tx line.
`timescale 1ns/1ps
module tb_regfile_dump_uart_tx;
  localparam int DW          = 32;
  localparam int AW          = 5;
  localparam int NR          = 32;
  localparam int CPB         = 4;
  localparam int FRAME_BYTES = 1 + NR * (DW / 8) + 1;
  localparam int BYTE_CYC    = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_dump_uart_tx_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  regfile_dump_uart_tx #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] snap [NR];
  assign bus.rd_data = regs[bus.rd_addr];

  int checks = 0;
  int errors = 0;
  int framing_errs = 0;
  int done_cnt = 0;
  int overlap = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame from the snapshot array.
  task automatic push_frame();
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NR; r++) begin
      for (int k = DW / 8 - 1; k >= 0; k--) begin
        b = snap[r][k*8 +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic start_dump();
    @(negedge clk);
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    while (n < 8000 && !found) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) found = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  // UART receiver: samples each bit at its middle.
  initial begin : rx_proc
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rb[i] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        if (bus.tx !== 1'b1) framing_errs++;
        rx_q.push_back(rb);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.done === 1'b1 && bus.busy === 1'b1) overlap <= overlap + 1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       low_seen;
    logic [7:0] hdr;
    logic       exp_bit;
    int         k;
    int         d0;

    hdr = 8'hA5;
    rst = 1'b1;
    bus.dump_req = 1'b0;
    for (int r = 0; r < NR; r++) regs[r] = '0;

    // Reset and idle line
    repeat (2) @(negedge clk);
    chk("rst_tx",      32'(bus.tx),      32'd1);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    rst = 1'b0;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) low_seen = 1'b1;
    end
    chk("idle_tx_high", 32'(low_seen), 32'd0);

    // Reset and request together: reset wins
    rst = 1'b1;
    bus.dump_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dump_req = 1'b0;
    chk("rst_req_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("rst_req_busy2", 32'(bus.busy), 32'd0);
    chk("rst_req_tx",    32'(bus.tx),   32'd1);

    // Full frame with reg 5 populated; header bit timing checked cycle by cycle
    regs[5] = 32'hDEADBEEF;
    snap = regs;
    push_frame();
    d0 = done_cnt;
    start_dump();
    chk("f1_busy_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < BYTE_CYC; i++) begin
      k = i / CPB;
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = hdr[3'(k - 1)];
      chk($sformatf("hdr_tx_c%0d", i), 32'(bus.tx), 32'(exp_bit));
      @(negedge clk);
    end
    wait_done("f1");
    chk("f1_rx_len", 32'(rx_q.size()), 32'(FRAME_BYTES));
    if (rx_q.size() == FRAME_BYTES) begin
      chk("f1_reg5_b0", 32'(rx_q[21]), 32'hDE);
      chk("f1_reg5_b1", 32'(rx_q[22]), 32'hAD);
      chk("f1_reg5_b2", 32'(rx_q[23]), 32'hBE);
      chk("f1_reg5_b3", 32'(rx_q[24]), 32'hEF);
      chk("f1_csum",    32'(rx_q[FRAME_BYTES-1]), 32'h22);
    end
    check_frame("f1");
    @(negedge clk);
    chk("f1_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("f1_busy_after", 32'(bus.busy), 32'd0);
    chk("f1_rd_addr_after", 32'(bus.rd_addr), 32'd0);

    // Request mid-frame and during DONE: both ignored
    snap = regs;
    push_frame();
    d0 = done_cnt;
    start_dump();
    repeat (10 * BYTE_CYC) @(negedge clk);
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    wait_done("f2");
    bus.dump_req = 1'b1;
    @(negedge clk);
    bus.dump_req = 1'b0;
    check_frame("f2");
    repeat (200) @(negedge clk);
    chk("f2_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("f2_no_restart_busy", 32'(bus.busy), 32'd0);
    chk("f2_no_restart_rx", 32'(rx_q.size()), 32'd0);

    // Reset mid-frame abandons the frame with no done pulse
    d0 = done_cnt;
    start_dump();
    repeat (40 * BYTE_CYC) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx",      32'(bus.tx),      32'd1);
    chk("abort_busy",    32'(bus.busy),    32'd0);
    chk("abort_rd_addr", 32'(bus.rd_addr), 32'd0);
    repeat (100) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    rx_q.delete();
    framing_errs = 0;

    regs[7] = 32'h12345678;
    snap = regs;
    push_frame();
    start_dump();
    wait_done("f3");
    if (rx_q.size() > 0) chk("f3_first_hdr", 32'(rx_q[0]), 32'hA5);
    check_frame("f3");

    // Snapshot: reg 3 written after its LOAD, reg 10 before its LOAD;
    // also a request in the cycle right after done must start a frame
    regs[3]  = 32'h01020304;
    regs[10] = 32'hCAFEF00D;
    snap = regs;
    snap[10] = 32'h00000022;
    push_frame();
    start_dump();
    chk("f4_restart_busy", 32'(bus.busy), 32'd1);
    repeat (900) @(negedge clk);
    regs[3]  = 32'h00000011;
    regs[10] = 32'h00000022;
    wait_done("f4");
    check_frame("f4");

    repeat (5) @(negedge clk);
    chk("no_framing_err", 32'(framing_errs), 32'd0);
    chk("done_busy_disjoint", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
